// File: rtl/arbiter_types.sv
// Types shared by the I/D cache arbiter: grant select, FSM state and memory operation.
package arbiter_types;

    typedef enum logic {
        SEL_INST = 1'b0,
        SEL_DATA = 1'b1
    } arbdatamux_sel_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    // Round-robin tie break: the side that did not win last time.
    function automatic arbdatamux_sel_t other_side(input arbdatamux_sel_t last);
        return (last == SEL_INST) ? SEL_DATA : SEL_INST;
    endfunction

endpackage

// File: rtl/cache_types.sv
// Shared cache geometry: line and physical-address widths used by the memory-side blocks.
package cache_types;

    localparam int CACHE_LINE_W = 256;
    localparam int CACHE_ADDR_W = 32;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates instruction- and data-cache line transfers onto one physical-memory port,
// alternating on contention and inserting a one-cycle release gap between transactions.
module cache_arbiter
    import cache_types::*;
    import arbiter_types::*;
#(
    parameter int LINE_W = CACHE_LINE_W,
    parameter int ADDR_W = CACHE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state_q, state_d;
    arbdatamux_sel_t   grant_q, grant_d;
    arbdatamux_sel_t   last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    mem_op_t           op_q, op_d;

    logic i_pend, d_pend;
    logic serving, done;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its peers; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= SEL_INST;
            last_grant_q <= SEL_INST;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_q         <= OP_READ;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_q         <= op_d;
        end
    end

    // NOTE: every signal gets a hold-value default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_d         = op_q;

        unique case (state_q)
            IDLE: begin
                if (i_pend || d_pend) begin
                    if (i_pend && d_pend) begin
                        grant_d = other_side(last_grant_q);
                    end else begin
                        grant_d = d_pend ? SEL_DATA : SEL_INST;
                    end

                    // A write-back wins over a simultaneous read from the data side.
                    if (grant_d == SEL_DATA) begin
                        addr_d  = d_address;
                        wdata_d = d_wdata;
                        op_d    = d_write ? OP_WRITE : OP_READ;
                    end else begin
                        addr_d  = i_address;
                        wdata_d = '0;
                        op_d    = OP_READ;
                    end
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (mem_resp) begin
                    last_grant_d = grant_q;
                    state_d      = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by rst so a reset cycle shows all-zero and drops any response.
    assign serving = (state_q == SERVE) && !rst;
    assign done    = serving && mem_resp;

    assign mem_read    = serving && (op_q == OP_READ);
    assign mem_write   = serving && (op_q == OP_WRITE);
    assign mem_address = serving ? addr_q  : '0;
    assign mem_wdata   = serving ? wdata_q : '0;

    assign i_resp  = done && (grant_q == SEL_INST);
    assign d_resp  = done && (grant_q == SEL_DATA);
    assign i_rdata = i_resp ? mem_rdata : '0;
    assign d_rdata = d_resp ? mem_rdata : '0;

endmodule
